// File: rtl/systolic_job_dispatcher.sv
// rtl/systolic_job_dispatcher.sv - job FIFO and launch/monitor FSM feeding the systolic NPU core
module systolic_job_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int N_MAX   = 4,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [ADDR_W-1:0]          job_addr_a,
  input  logic [ADDR_W-1:0]          job_addr_b,
  input  logic [ADDR_W-1:0]          job_addr_c,
  input  logic [3:0]                 job_n,
  input  logic [3:0]                 job_tag,
  output logic [ADDR_W-1:0]          addr_A,
  output logic [ADDR_W-1:0]          addr_B,
  output logic [ADDR_W-1:0]          addr_C,
  output logic [3:0]                 n,
  output logic                       new_data,
  input  logic                       core_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       job_done,
  output logic [3:0]                 done_tag,
  output logic [15:0]                last_cycles,
  output logic                       timeout_err,
  output logic                       invalid_err,
  output logic [15:0]                jobs_completed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_CLEAR, RUN, REPORT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
    logic [3:0]        n;
    logic [3:0]        tag;
  } job_t;

  job_t              mem [DEPTH];
  job_t              head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state;
  state_t            state_nx;
  logic [15:0]       cycles;
  logic              push;
  logic              pop;
  logic              load;
  logic              reject;
  logic              abort;
  logic              finish;
  logic              head_ok;

  assign head       = mem[rd_ptr];
  assign head_ok    = (head.n != 4'd0) && (head.n <= 4'(N_MAX));
  assign job_ready  = (count < CNT_W'(DEPTH));
  assign push       = job_valid && job_ready;
  assign fifo_count = count;
  assign new_data   = (state == LAUNCH);
  assign job_done   = (state == REPORT);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    reject   = 1'b0;
    abort    = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_ok) begin
            load     = 1'b1;
            state_nx = LAUNCH;
          end else begin
            reject = 1'b1;
          end
        end
      end
      LAUNCH: state_nx = WAIT_CLEAR;
      // a done level still high from the previous job must drop before we trust it
      WAIT_CLEAR: begin
        if (!core_done) begin
          state_nx = RUN;
        end else if (cycles >= 16'(TIMEOUT)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (core_done) begin
          finish   = 1'b1;
          state_nx = REPORT;
        end else if (cycles >= 16'(TIMEOUT)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: job_addr_a, b: job_addr_b, c: job_addr_c, n: job_n, tag: job_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cycles         <= '0;
      addr_A         <= '0;
      addr_B         <= '0;
      addr_C         <= '0;
      n              <= '0;
      done_tag       <= '0;
      last_cycles    <= '0;
      timeout_err    <= 1'b0;
      invalid_err    <= 1'b0;
      jobs_completed <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) done_tag <= head.tag;
      if (load) begin
        addr_A <= head.a;
        addr_B <= head.b;
        addr_C <= head.c;
        n      <= head.n;
      end
      // cycle k after the launch cycle reads k while waiting for the core
      if (state == LAUNCH) begin
        cycles <= 16'd1;
      end else if ((state == WAIT_CLEAR) || (state == RUN)) begin
        cycles <= cycles + 16'd1;
      end
      invalid_err <= reject;
      timeout_err <= abort;
      if (finish) begin
        last_cycles <= cycles + 16'd1;
        if (jobs_completed != 16'hFFFF) jobs_completed <= jobs_completed + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_job_dispatcher.sv
// tb/tb_systolic_job_dispatcher.sv - self-checking bench for systolic_job_dispatcher
module tb_systolic_job_dispatcher;
  localparam int DEPTH   = 4;
  localparam int N_MAX   = 4;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 50;
  localparam int K_DONE  = 0;
  localparam int K_INV   = 1;
  localparam int K_TO    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [ADDR_W-1:0] job_addr_a = '0, job_addr_b = '0, job_addr_c = '0;
  logic [3:0]        job_n = '0, job_tag = '0;
  logic [ADDR_W-1:0] addr_A, addr_B, addr_C;
  logic [3:0]        n;
  logic              new_data;
  logic              core_done = 1'b0;
  logic              busy;
  logic [2:0]        fifo_count;
  logic              job_done;
  logic [3:0]        done_tag;
  logic [15:0]       last_cycles;
  logic              timeout_err, invalid_err;
  logic [15:0]       jobs_completed;

  always #5 clk = ~clk;

  systolic_job_dispatcher #(.DEPTH(DEPTH), .N_MAX(N_MAX), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_addr_a(job_addr_a), .job_addr_b(job_addr_b), .job_addr_c(job_addr_c),
    .job_n(job_n), .job_tag(job_tag), .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C),
    .n(n), .new_data(new_data), .core_done(core_done), .busy(busy), .fifo_count(fifo_count),
    .job_done(job_done), .done_tag(done_tag), .last_cycles(last_cycles),
    .timeout_err(timeout_err), .invalid_err(invalid_err), .jobs_completed(jobs_completed)
  );

  // s: core_done stays high (stale) for relative cycles < s; d: cycle after launch where done rises
  typedef struct {
    logic [ADDR_W-1:0] a, b, c;
    logic [3:0]        n, tag;
    int                s, d;
  } job_t;

  typedef struct {
    job_t job;
    int   kind;
    int   last;
  } vec_t;

  int   tests = 0, fails = 0;
  job_t mq[$];
  job_t cur, pend_job;
  bit   have_cur = 0, inflight = 0, pend_pop = 0, prev_nd = 0;
  int   rel = 0, evt = 0, busy_end = 0, exp_kind = 0;
  int   pushed = 0, popped = 0, completed = 0, exp_tag = 0;
  int   ev_count = 0, ev_kind = 0, ev_tag = 0, ev_last = 0;
  int   launch_log[$];

  function automatic job_t mk(int a, int b, int c, int nn, int tag, int s, int d);
    job_t j;
    j.a = ADDR_W'(a); j.b = ADDR_W'(b); j.c = ADDR_W'(c);
    j.n = 4'(nn); j.tag = 4'(tag); j.s = s; j.d = d;
    return j;
  endfunction

  function automatic vec_t mkv(job_t j, int kind, int last);
    vec_t v;
    v.job = j; v.kind = kind; v.last = last;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: account the push, then at the falling edge check outputs and drive the core model.
  task automatic cycle();
    bit v, r, exp_jd, exp_to, exp_busy;
    int jc;
    job_t j;
    r = rst;
    v = job_valid && job_ready && !rst;
    @(negedge clk);
    if (r) begin
      mq.delete();
      pushed = 0; popped = 0; completed = 0; exp_tag = 0;
      have_cur = 0; inflight = 0; pend_pop = 0; prev_nd = 0;
      core_done = 1'b0;
      chk("no_new_data_in_reset", new_data, 0);
      return;
    end
    if (v) begin
      mq.push_back(pend_job);
      pushed++;
    end
    chk("pop_timing", new_data || invalid_err, pend_pop);
    if (new_data) begin
      chk("new_data_gap", prev_nd, 0);
      if (mq.size() == 0) begin
        chk("launch_has_job", 0, 1);
      end else begin
        cur = mq.pop_front();
        popped++;
        have_cur = 1; inflight = 1; rel = 0;
        exp_tag = cur.tag;
        launch_log.push_back(int'(cur.tag));
        chk("launch_n_legal", (cur.n >= 1) && (cur.n <= N_MAX), 1);
        jc = (cur.s > 1) ? cur.s : 1;
        if (cur.d > jc && cur.d <= TIMEOUT) begin
          exp_kind = K_DONE; evt = cur.d + 1; busy_end = cur.d + 1;
        end else begin
          exp_kind = K_TO; evt = TIMEOUT + 1; busy_end = TIMEOUT;
        end
      end
    end else if (inflight) begin
      rel++;
    end
    if (invalid_err) begin
      if (mq.size() == 0) begin
        chk("reject_has_job", 0, 1);
      end else begin
        j = mq.pop_front();
        popped++;
        exp_tag = j.tag;
        chk("reject_n_illegal", (j.n == 0) || (j.n > N_MAX), 1);
      end
      ev_kind = K_INV; ev_tag = done_tag; ev_count++;
    end
    exp_jd = inflight && exp_kind == K_DONE && rel == evt;
    exp_to = inflight && exp_kind == K_TO && rel == evt;
    if (exp_jd) completed++;
    chk("job_done", job_done, exp_jd);
    chk("timeout_err", timeout_err, exp_to);
    if (exp_jd) chk("last_cycles", last_cycles, cur.d + 1);
    if (job_done) begin
      ev_kind = K_DONE; ev_tag = done_tag; ev_last = last_cycles; ev_count++;
    end
    if (timeout_err) begin
      ev_kind = K_TO; ev_tag = done_tag; ev_count++;
    end
    chk("jobs_completed", jobs_completed, completed);
    exp_busy = inflight && rel <= busy_end;
    chk("busy", busy, exp_busy);
    chk("fifo_count", fifo_count, pushed - popped);
    chk("job_ready", job_ready, (pushed - popped) < DEPTH);
    chk("done_tag", done_tag, exp_tag);
    if (have_cur) begin
      chk("addr_A", addr_A, cur.a);
      chk("addr_B", addr_B, cur.b);
      chk("addr_C", addr_C, cur.c);
      chk("n", n, cur.n);
    end
    pend_pop = !exp_busy && (pushed - popped) > 0;
    prev_nd = new_data;
    if (have_cur) core_done = (rel < cur.s) ? 1'b1 : (rel >= cur.d);
  endtask

  task automatic push_job(input job_t j, output int waited);
    bit acc, ok;
    pend_job = j;
    job_addr_a = j.a; job_addr_b = j.b; job_addr_c = j.c;
    job_n = j.n; job_tag = j.tag;
    job_valid = 1'b1;
    waited = 0; ok = 0;
    for (int k = 0; k < 500; k++) begin
      acc = job_ready;
      cycle();
      if (acc) begin ok = 1; break; end
      waited++;
    end
    if (!ok) chk("push_accepted_in_bound", 0, 1);
    job_valid = 1'b0;
  endtask

  task automatic wait_event(input int e0);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (ev_count != e0) begin ok = 1; break; end
    end
    if (!ok) chk("event_in_bound", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      cycle();
      if (pushed == popped && !busy) begin ok = 1; break; end
    end
    if (!ok) chk("drain_in_bound", 0, 1);
  endtask

  initial begin
    vec_t tbl[7];
    int   w, e0, l0, jc;
    int   order[6];
    job_t j;

    // reset held with a job offered
    rst = 1'b1;
    job_valid = 1'b1; job_addr_a = 12'h123; job_n = 4'd2; job_tag = 4'd5;
    repeat (3) cycle();
    rst = 1'b0;
    job_valid = 1'b0;
    cycle();
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_status", {busy, job_done, timeout_err, invalid_err, new_data}, 0);
    chk("rst_done_tag", done_tag, 0);
    chk("rst_last_cycles", last_cycles, 0);
    chk("rst_jobs_completed", jobs_completed, 0);
    chk("rst_addr", {addr_A, addr_B, addr_C, n}, 0);

    tbl[0] = mkv(mk(0, 16, 32, 4, 3, 0, 20), K_DONE, 21);
    tbl[1] = mkv(mk(1, 2, 3, 0, 7, 0, 5), K_INV, 0);
    tbl[2] = mkv(mk(4, 5, 6, 5, 8, 0, 5), K_INV, 0);
    tbl[3] = mkv(mk(64, 80, 96, 2, 9, 0, 5), K_DONE, 6);
    tbl[4] = mkv(mk(7, 8, 9, 3, 10, 2, 12), K_DONE, 13);
    tbl[5] = mkv(mk(10, 11, 12, 1, 11, 0, 1000), K_TO, 0);
    tbl[6] = mkv(mk(13, 14, 15, 4, 12, 1, 3), K_DONE, 4);
    for (int i = 0; i < 7; i++) begin
      e0 = ev_count;
      l0 = launch_log.size();
      push_job(tbl[i].job, w);
      wait_event(e0);
      chk("tbl_kind", ev_kind, tbl[i].kind);
      chk("tbl_tag", ev_tag, tbl[i].job.tag);
      chk("tbl_launches", launch_log.size() - l0, tbl[i].kind != K_INV);
      if (tbl[i].kind == K_DONE) chk("tbl_last_cycles", ev_last, tbl[i].last);
    end
    wait_idle();

    // five jobs pushed behind a long-running one: the fifth must stall on a full FIFO
    launch_log.delete();
    order[0] = 15;
    push_job(mk(100, 200, 300, 4, 15, 0, 30), w);
    for (int t = 0; t < 5; t++) begin
      push_job(mk(t * 4, t * 4 + 1, t * 4 + 2, 2, t, 0, 6), w);
      order[t + 1] = t;
      if (t == 4) chk("fifth_push_waits", w > 0, 1);
    end
    wait_idle();
    chk("b2b_launches", launch_log.size(), 6);
    for (int i = 0; i < 6 && i < launch_log.size(); i++) chk("b2b_order", launch_log[i], order[i]);

    // randomized jobs against the reference model
    for (int r = 0; r < 40; r++) begin
      j.a = ADDR_W'($urandom); j.b = ADDR_W'($urandom); j.c = ADDR_W'($urandom);
      j.n = 4'($urandom_range(0, 6));
      j.tag = 4'($urandom);
      j.s = $urandom_range(0, 3);
      jc = (j.s > 1) ? j.s : 1;
      j.d = ($urandom_range(0, 7) == 0) ? 1000 : jc + 1 + $urandom_range(0, 25);
      push_job(j, w);
      repeat ($urandom_range(0, 20)) cycle();
    end
    wait_idle();

    // reset in the middle of a job with more queued
    push_job(mk(1, 1, 1, 3, 1, 0, 40), w);
    push_job(mk(2, 2, 2, 3, 2, 0, 40), w);
    push_job(mk(3, 3, 3, 3, 3, 0, 40), w);
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("midrst_busy", busy, 0);
    chk("midrst_fifo_count", fifo_count, 0);
    chk("midrst_jobs_completed", jobs_completed, 0);
    repeat (5) cycle();
    chk("midrst_no_launch", {new_data, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
